merc16_control_fsm: RTL and testbench
=====================================

# merc16_control_fsm

Multi-cycle main controller for the MERC-16 processor. Sequences the PC/memory subsystem, register file and ALU through fetch, decode, execute, memory and write-back states per instruction. Consumes the opcode from the instruction register and the ALU Zero flag. Drives every write-enable and mux select in the datapath.

## Interface
Parameters:
- none

Ports:
- Clock  input  1  system clock; all state changes on rising edge
- Reset  input  1  synchronous, active-high; one clock, synchronous reset, active-high
- Opcode  input  4  Instruction[15:12] from the IR
- Zero  input  1  ALU result == 0 (combinational, current cycle)
- PC_Source  output  2  0 = ALU result (combinational), 1 = ALU_Out register, 2 = jump target {PC[15:12], JumpImmediate, 1'b0}
- PC_Write  output  1  PC load enable
- InstData  output  1  memory address select: 0 = PC, 1 = ALU_Out
- IR_Write  output  1  instruction register load
- MemWrite  output  1  memory write strobe (data = SrcB)
- RegWrite  output  1  register file write
- RegDst  output  1  0 = rt field, 1 = rd field
- MemToReg  output  1  0 = ALU_Out, 1 = RegData
- ALUSrcA  output  1  0 = PC, 1 = SrcA
- ALUSrcB  output  2  0 = SrcB, 1 = constant 2, 2 = sign-ext imm, 3 = sign-ext imm << 1
- ALUOp  output  2  0 = add, 1 = sub, 2 = function from Opcode[1:0]
- Halted  output  1  high while in HALT
- State  output  4  current state encoding (debug)

## Operation
- Opcode map: 0-3 R-type (ADD/SUB/AND/OR), 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 J, 15 HALT, 10-14 illegal (NOP).
- States: FETCH0, FETCH1, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WRITE, WB_ALU, WB_MEM, BRANCH, JUMP, HALT.
- FETCH0: InstData=0; memory addressed by PC. No enables. -> FETCH1.
- FETCH1: IR_Write=1; ALUSrcA=0, ALUSrcB=1, ALUOp=0, PC_Source=0, PC_Write=1 (PC += 2). -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALU_Out). Dispatch: R -> EXEC_R; ADDI -> EXEC_I; LW/SW -> MEM_ADDR; BEQ/BNE -> BRANCH; J -> JUMP; HALT -> HALT; illegal -> FETCH0.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=2. -> WB_ALU with RegDst=1.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp=0. -> WB_ALU with RegDst=0.
- WB_ALU: RegWrite=1, MemToReg=0; RegDst latched from the exec path. -> FETCH0.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. -> MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: InstData=1. -> WB_MEM.
- WB_MEM: InstData=1, RegWrite=1, MemToReg=1, RegDst=0. -> FETCH0.
- MEM_WRITE: InstData=1, MemWrite=1. -> FETCH0.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PC_Source=1; PC_Write = Zero (BEQ) or ~Zero (BNE). -> FETCH0.
- JUMP: PC_Source=2, PC_Write=1. -> FETCH0.
- HALT: all enables 0, Halted=1; remains until Reset.
- Outputs not listed for a state are 0. All outputs are Moore-decoded from the state, except PC_Write in BRANCH, which is combinational on Zero.

## Timing
- Reset: state = FETCH0 at the next edge. While Reset is high, all write enables are forced to 0 combinationally. All other outputs are 0 and Halted=0.
- Reset mid-instruction aborts the instruction with no partial writes in the reset cycle. This includes a reset during MEM_WRITE.
- Cycles per instruction: R/ADDI 5, LW 6, SW 5, BEQ/BNE/J 4, illegal 3.
- Memory has one-cycle synchronous read latency. The address is held stable for the cycle before a capture (FETCH0→FETCH1, MEM_READ→WB_MEM).
- At most one of IR_Write, MemWrite and RegWrite is high in any cycle.

## Configuration
- MERC16_PERF_COUNT_EN defined: adds outputs CycleCount[31:0] and RetiredCount[31:0].
  - Both clear on Reset.
  - CycleCount increments every non-reset cycle except in HALT.
  - RetiredCount increments on the cycle leaving WB_ALU, WB_MEM, MEM_WRITE, BRANCH, JUMP, or DECODE-for-illegal.
  - Both counters wrap at 2^32.
- Undefined: no counters and no extra ports.

## Test plan
- Reset for 2 cycles, then Opcode=0 held → State sequence FETCH0, FETCH1, DECODE, EXEC_R, WB_ALU repeating. RegWrite=1 and RegDst=1 only in WB_ALU. PC_Write=1 only in FETCH1.
- Opcode=5 (LW) → 6-cycle loop. InstData=1 in MEM_READ and WB_MEM. MemToReg=1 with RegWrite=1 in WB_MEM. Opcode=6 → MemWrite=1 for exactly one cycle, RegWrite never asserted.
- Opcode=7 with Zero=1 in BRANCH → PC_Write=1 and PC_Source=1. With Zero=0 → PC_Write=0. Opcode=8 → inverse behaviour.
- Opcode=9 → JUMP asserts PC_Source=2 and PC_Write=1. Opcode=12 → DECODE returns to FETCH0 with no writes.
- Opcode=15 → Halted=1 and State stable for 20 cycles with no enables. Assert Reset during MEM_WRITE → MemWrite=0 that cycle and FETCH0 on the next edge.
- With MERC16_PERF_COUNT_EN: 3 R-type instructions after reset → RetiredCount=3, CycleCount=15.

Source files
------------

// File: rtl/merc16_control_fsm.sv
// MERC-16 multi-cycle main controller: sequences fetch/decode/execute/memory/write-back.
// Optional MERC16_PERF_COUNT_EN adds CycleCount and RetiredCount outputs.
module merc16_control_fsm (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [3:0] Opcode,
   input  logic       Zero,
   output logic [1:0] PC_Source,
   output logic       PC_Write,
   output logic       InstData,
   output logic       IR_Write,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemToReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       Halted,
   output logic [3:0] State
`ifdef MERC16_PERF_COUNT_EN
   ,
   output logic [31:0] CycleCount,
   output logic [31:0] RetiredCount
`endif
);

   typedef enum logic [3:0] {
      StFetch0   = 4'd0,
      StFetch1   = 4'd1,
      StDecode   = 4'd2,
      StExecR    = 4'd3,
      StExecI    = 4'd4,
      StMemAddr  = 4'd5,
      StMemRead  = 4'd6,
      StMemWrite = 4'd7,
      StWbAlu    = 4'd8,
      StWbMem    = 4'd9,
      StBranch   = 4'd10,
      StJump     = 4'd11,
      StHalt     = 4'd12
   } state_t;

   typedef struct packed {
      logic [1:0] pc_source;
      logic       pc_write;
      logic       inst_data;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       halted;
   } ctrl_t;

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_out;
   logic   is_sw_q, is_bne_q;
   logic   branch_take;

   // Output bundle for a state; from_exec_r carries the RegDst choice into WB_ALU.
   function automatic ctrl_t decode_ctrl(state_t st, logic from_exec_r);
      ctrl_t c;
      c = '0;
      case (st)
         StFetch1: begin
            c.ir_write  = 1'b1;
            c.alu_src_b = 2'd1;
            c.pc_write  = 1'b1;
         end
         StDecode:  c.alu_src_b = 2'd3;
         StExecR: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'd2;
         end
         StExecI, StMemAddr: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'd2;
         end
         StMemRead: c.inst_data = 1'b1;
         StMemWrite: begin
            c.inst_data = 1'b1;
            c.mem_write = 1'b1;
         end
         StWbAlu: begin
            c.reg_write = 1'b1;
            c.reg_dst   = from_exec_r;
         end
         StWbMem: begin
            c.inst_data  = 1'b1;
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         StBranch: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'd1;
            c.pc_source = 2'd1;
         end
         StJump: begin
            c.pc_source = 2'd2;
            c.pc_write  = 1'b1;
         end
         StHalt:    c.halted = 1'b1;
         default:   ;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch0:   state_d = StFetch1;
         StFetch1:   state_d = StDecode;
         StDecode: begin
            case (Opcode)
               4'd0, 4'd1, 4'd2, 4'd3: state_d = StExecR;
               4'd4:                   state_d = StExecI;
               4'd5, 4'd6:             state_d = StMemAddr;
               4'd7, 4'd8:             state_d = StBranch;
               4'd9:                   state_d = StJump;
               4'd15:                  state_d = StHalt;
               default:                state_d = StFetch0;
            endcase
         end
         StExecR, StExecI: state_d = StWbAlu;
         StMemAddr:  state_d = is_sw_q ? StMemWrite : StMemRead;
         StMemRead:  state_d = StWbMem;
         StHalt:     state_d = StHalt;
         default:    state_d = StFetch0;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= StFetch0;
         ctrl_q   <= '0;
         is_sw_q  <= 1'b0;
         is_bne_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= decode_ctrl(state_d, state_q == StExecR);
         if (state_q == StDecode) begin
            is_sw_q  <= (Opcode == 4'd6);
            is_bne_q <= (Opcode == 4'd8);
         end
      end
   end

   assign ctrl_out    = Reset ? '0 : ctrl_q;
   assign branch_take = (state_q == StBranch) && (Zero ^ is_bne_q);

   assign PC_Source = ctrl_out.pc_source;
   assign PC_Write  = !Reset && (ctrl_q.pc_write || branch_take);
   assign InstData  = ctrl_out.inst_data;
   assign IR_Write  = ctrl_out.ir_write;
   assign MemWrite  = ctrl_out.mem_write;
   assign RegWrite  = ctrl_out.reg_write;
   assign RegDst    = ctrl_out.reg_dst;
   assign MemToReg  = ctrl_out.mem_to_reg;
   assign ALUSrcA   = ctrl_out.alu_src_a;
   assign ALUSrcB   = ctrl_out.alu_src_b;
   assign ALUOp     = ctrl_out.alu_op;
   assign Halted    = ctrl_out.halted;
   assign State     = Reset ? 4'd0 : state_q;

`ifdef MERC16_PERF_COUNT_EN
   logic retire;

   assign retire = (state_q == StWbAlu) || (state_q == StWbMem) || (state_q == StMemWrite) ||
                   (state_q == StBranch) || (state_q == StJump) ||
                   ((state_q == StDecode) && (state_d == StFetch0));

   always_ff @(posedge Clock) begin
      if (Reset) begin
         CycleCount   <= '0;
         RetiredCount <= '0;
      end else begin
         if (state_q != StHalt) CycleCount <= CycleCount + 32'd1;
         if (retire)            RetiredCount <= RetiredCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_merc16_control_fsm.sv
// Directed bench for merc16_control_fsm: per-cycle expected outputs go through a scoreboard queue.
module tb_merc16_control_fsm;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [3:0] Opcode = 4'd0;
   logic       Zero = 1'b0;
   logic [1:0] PC_Source, ALUSrcB, ALUOp;
   logic       PC_Write, InstData, IR_Write, MemWrite, RegWrite, RegDst, MemToReg, ALUSrcA;
   logic       Halted;
   logic [3:0] State;
`ifdef MERC16_PERF_COUNT_EN
   logic [31:0] CycleCount, RetiredCount;
`endif

   merc16_control_fsm dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Opcode    (Opcode),
      .Zero      (Zero),
      .PC_Source (PC_Source),
      .PC_Write  (PC_Write),
      .InstData  (InstData),
      .IR_Write  (IR_Write),
      .MemWrite  (MemWrite),
      .RegWrite  (RegWrite),
      .RegDst    (RegDst),
      .MemToReg  (MemToReg),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .Halted    (Halted),
      .State     (State)
`ifdef MERC16_PERF_COUNT_EN
      ,
      .CycleCount   (CycleCount),
      .RetiredCount (RetiredCount)
`endif
   );

   always #5 Clock = ~Clock;

   localparam int F0 = 0, F1 = 1, DEC = 2, EXR = 3, EXI = 4, MA = 5, MR = 6, MW = 7;
   localparam int WBA = 8, WBM = 9, BR = 10, JMP = 11, HLT = 12;

   typedef struct {
      string      tag;
      logic [18:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   logic [18:0] obs;
   assign obs = {PC_Source, PC_Write, InstData, IR_Write, MemWrite, RegWrite, RegDst, MemToReg,
                 ALUSrcA, ALUSrcB, ALUOp, Halted, State};

   // Expected outputs straight from the per-state control table.
   function automatic logic [18:0] model(int st, logic [3:0] op, logic z);
      logic [1:0] pcs, asb, aop;
      logic       pcw, idata, irw, mw, rw, rd, m2r, asa, hlt;
      {pcs, asb, aop} = '0;
      {pcw, idata, irw, mw, rw, rd, m2r, asa, hlt} = '0;
      case (st)
         F1: begin irw = 1; asb = 2'd1; pcw = 1; end
         DEC: asb = 2'd3;
         EXR: begin asa = 1; aop = 2'd2; end
         EXI, MA: begin asa = 1; asb = 2'd2; end
         MR: idata = 1;
         MW: begin idata = 1; mw = 1; end
         WBA: begin rw = 1; rd = (op <= 4'd3); end
         WBM: begin idata = 1; rw = 1; m2r = 1; end
         BR: begin asa = 1; aop = 2'd1; pcs = 2'd1; pcw = (op == 4'd8) ? ~z : z; end
         JMP: begin pcs = 2'd2; pcw = 1; end
         HLT: hlt = 1;
         default: ;
      endcase
      return {pcs, pcw, idata, irw, mw, rw, rd, m2r, asa, asb, aop, hlt, 4'(st)};
   endfunction

   function automatic int seq_state(logic [3:0] op, int i);
      int exec;
      if (i == 0) return F0;
      if (i == 1) return F1;
      if (i == 2) return DEC;
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3: exec = EXR;
         4'd4:                   exec = EXI;
         4'd5, 4'd6:             exec = MA;
         4'd7, 4'd8:             exec = BR;
         4'd9:                   exec = JMP;
         4'd15:                  exec = HLT;
         default:                exec = F0;
      endcase
      if (i == 3) return exec;
      if (exec == EXR || exec == EXI) return WBA;
      if (op == 4'd6) return MW;
      return (i == 4) ? MR : WBM;
   endfunction

   function automatic int seq_len(logic [3:0] op);
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6: return 5;
         4'd5:                               return 6;
         4'd7, 4'd8, 4'd9, 4'd15:            return 4;
         default:                            return 3;
      endcase
   endfunction

   task automatic pop_check();
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: observed %h required an expectation", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.v)
         else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic next_cycle();
      @(posedge Clock);
      @(negedge Clock);
      #1;
   endtask

   // Runs the first n states of an instruction, starting at a negedge in FETCH0.
   task automatic run_instr(logic [3:0] op, logic z, int n);
      int st;
      Opcode = op;
      Zero   = z;
      #1;
      for (int i = 0; i < n; i++) begin
         st = seq_state(op, i);
         sb.push_back('{$sformatf("op%0d_z%0d_st%0d", op, z, st), model(st, op, z)});
         pop_check();
         next_cycle();
      end
   endtask

   task automatic reset_check(string tag);
      Reset = 1'b1;
      #1;
      sb.push_back('{tag, 19'd0});
      pop_check();
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, required finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge Clock);
      @(posedge Clock);
      @(negedge Clock);
      #1;
      sb.push_back('{"reset_held", 19'd0});
      pop_check();
      Reset = 1'b0;
      #1;

      for (int k = 0; k < 3; k++) run_instr(4'(k), 1'b0, seq_len(4'(k)));
`ifdef MERC16_PERF_COUNT_EN
      n_checks++;
      assert (CycleCount === 32'd15)
      else begin
         n_fail++;
         $error("FAIL cycle_count: observed %0d expected 15", CycleCount);
      end
      n_checks++;
      assert (RetiredCount === 32'd3)
      else begin
         n_fail++;
         $error("FAIL retired_count: observed %0d expected 3", RetiredCount);
      end
`endif

      run_instr(4'd3, 1'b0, 5);
      run_instr(4'd4, 1'b0, 5);
      run_instr(4'd5, 1'b0, 6);
      run_instr(4'd6, 1'b0, 5);
      run_instr(4'd7, 1'b1, 4);
      run_instr(4'd7, 1'b0, 4);
      run_instr(4'd8, 1'b1, 4);
      run_instr(4'd8, 1'b0, 4);
      run_instr(4'd9, 1'b0, 4);
      run_instr(4'd12, 1'b0, 3);
      run_instr(4'd10, 1'b1, 3);

      // Abort a store in MEM_WRITE, then the next instruction must start clean.
      run_instr(4'd6, 1'b0, 4);
      reset_check("reset_in_mem_write");
      run_instr(4'd5, 1'b0, 6);

      run_instr(4'd15, 1'b0, 4);
      for (int k = 0; k < 20; k++) begin
         sb.push_back('{$sformatf("halt_hold%0d", k), model(HLT, 4'd15, 1'b0)});
         pop_check();
         next_cycle();
      end
      reset_check("reset_from_halt");
      run_instr(4'd1, 1'b0, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
